// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit frame sequencer: state encoding,
// line levels, parity selectors and the bit-counter width helper.
package uart_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_DEF = 8;

  typedef struct packed {
    logic en;
    logic typ;
  } par_cfg_t;

  function automatic int cnt_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// LSB-first shift register plus bit counter; the frame FSM in the top
// decides when to load, shift and advance/clear the counter.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CW         = cnt_width(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  shift_i,
  input  logic                  cnt_inc_i,
  input  logic                  cnt_clr_i,
  output logic                  bit_o,
  output logic                  ser_done_o
);

  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i)
      sr_d = data_i;
    else if (shift_i)
      sr_d = {1'b0, sr_q[DATA_WIDTH-1:1]};
    if (cnt_clr_i)
      cnt_d = '0;
    else if (cnt_inc_i)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  // sr_q[0] is always the bit that goes on the line at the next DATA edge
  assign bit_o      = sr_q[0];
  assign ser_done_o = (cnt_q == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer: start, data LSB-first, optional parity, stop.
// All outputs are registered and change on the same edge as the state.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  frame_done
);

  logic [2:0] state_q, state_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       par_q, par_d;
  par_cfg_t   cfg_q, cfg_d;

  logic load, shift, cnt_inc, cnt_clr;
  logic ser_bit, ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .CLK        (CLK),
    .RST        (RST),
    .load_i     (load),
    .data_i     (P_DATA),
    .shift_i    (shift),
    .cnt_inc_i  (cnt_inc),
    .cnt_clr_i  (cnt_clr),
    .bit_o      (ser_bit),
    .ser_done_o (ser_done)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    par_d   = par_q;
    cfg_d   = cfg_q;
    load    = 1'b0;
    shift   = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;

    case (state_q)
      ST_IDLE, ST_STOP: begin
        if (Data_Valid) begin
          // Parity is frozen here so later P_DATA changes cannot leak in
          load    = 1'b1;
          cfg_d   = '{en: PAR_EN, typ: PAR_TYP};
          par_d   = (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
          state_d = ST_START;
          tx_d    = START_BIT;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          tx_d    = IDLE_LEVEL;
          busy_d  = 1'b0;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        tx_d    = ser_bit;
        shift   = 1'b1;
        cnt_clr = 1'b1;
      end
      ST_DATA: begin
        if (ser_done) begin
          cnt_clr = 1'b1;
          if (cfg_q.en) begin
            state_d = ST_PARITY;
            tx_d    = par_q;
          end else begin
            state_d = ST_STOP;
            tx_d    = STOP_BIT;
            done_d  = 1'b1;
          end
        end else begin
          tx_d    = ser_bit;
          shift   = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      ST_PARITY: begin
        state_d = ST_STOP;
        tx_d    = STOP_BIT;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      par_q   <= 1'b0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      par_q   <= par_d;
      cfg_q   <= cfg_d;
    end
  end

  assign TX_OUT     = tx_q;
  assign Busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: a frame-list model predicts every cycle's
// line/Busy/frame_done, plus literal sequences for the directed frames.
module tb_uart_tx_frame_ctrl;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid, PAR_EN, PAR_TYP;
  logic          TX_OUT, Busy, frame_done;

  always #5 CLK = ~CLK;

  uart_tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } obs_t;

  localparam obs_t IDLE_OBS = '{1'b1, 1'b0, 1'b0};

  obs_t cur = IDLE_OBS;
  obs_t pend[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a frame is the list of line cycles it will produce; a new one is
  // only taken when nothing of the current frame remains after this cycle.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend.delete();
      cur <= IDLE_OBS;
    end else begin
      if (pend.size() == 0 && Data_Valid) begin
        pend.push_back('{1'b0, 1'b1, 1'b0});
        for (int i = 0; i < DW; i++) pend.push_back('{P_DATA[i], 1'b1, 1'b0});
        if (PAR_EN) pend.push_back('{(^P_DATA) ^ PAR_TYP, 1'b1, 1'b0});
        pend.push_back('{1'b1, 1'b1, 1'b1});
      end
      if (pend.size() > 0) cur <= pend.pop_front();
      else                 cur <= IDLE_OBS;
    end
  end

  always @(negedge CLK) begin
    chk("model_tx",   TX_OUT,     cur.tx);
    chk("model_busy", Busy,       cur.busy);
    chk("model_done", frame_done, cur.done);
  end

  // Send one byte, then record n line bits, Busy cycles and the frame_done slot.
  // Inputs are scrambled after acceptance; inj pulses Data_Valid with 0x00.
  task automatic send_cap(input logic [DW-1:0] d, input logic en, input logic typ,
                          input int n, input int inj,
                          output logic [15:0] seq, output int bcnt, output int dpos);
    @(posedge CLK); #1;
    P_DATA = d; PAR_EN = en; PAR_TYP = typ; Data_Valid = 1'b1;
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
    P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
    seq = '0; bcnt = 0; dpos = 0;
    for (int i = 1; i <= n + 2; i++) begin
      @(negedge CLK);
      if (i <= n) seq = {seq[14:0], TX_OUT};
      if (Busy) bcnt++;
      if (frame_done && dpos == 0) dpos = i;
      if (i == inj) begin
        P_DATA = '0; Data_Valid = 1'b1; PAR_TYP = ~PAR_TYP;
      end else begin
        Data_Valid = 1'b0;
      end
    end
  endtask

  initial begin
    logic [15:0] seq;
    int bc, dp, nd;

    RST = 1'b1; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_tx", TX_OUT, 1'b1);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    RST = 1'b0;

    send_cap(8'hA5, 1'b1, 1'b0, 11, 0, seq, bc, dp);
    chk("a5_even_seq", seq, 16'h0295);
    chk("a5_even_busy", bc, 11);
    chk("a5_even_done", dp, 11);

    send_cap(8'hA5, 1'b1, 1'b1, 11, 0, seq, bc, dp);
    chk("a5_odd_seq", seq, 16'h0297);

    send_cap(8'h3C, 1'b0, 1'b0, 10, 0, seq, bc, dp);
    chk("3c_nopar_seq", seq, 16'h0079);
    chk("3c_nopar_busy", bc, 10);
    chk("3c_nopar_done", dp, 10);

    send_cap(8'hFF, 1'b1, 1'b0, 11, 4, seq, bc, dp);
    chk("ignore_seq", seq, 16'h03FD);
    chk("ignore_busy", bc, 11);

    // Back-to-back: second request presented during the first stop cycle
    @(posedge CLK); #1;
    P_DATA = 8'h01; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(posedge CLK); #1;
    Data_Valid = 1'b0; P_DATA = 8'hFF;
    bc = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (Busy) bc++;
      if (frame_done) begin
        nd++;
        Data_Valid = (nd == 1);
      end else begin
        Data_Valid = 1'b0;
      end
    end
    chk("b2b_busy", bc, 22);
    chk("b2b_frames", nd, 2);

    // Asynchronous reset during data bit 3 of 0x55
    @(posedge CLK); #1;
    P_DATA = 8'h55; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
    repeat (5) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_tx", TX_OUT, 1'b1);
    chk("async_rst_busy", Busy, 1'b0);
    chk("async_rst_done", frame_done, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    bc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (Busy || !TX_OUT) bc++;
    end
    chk("post_rst_idle", bc, 0);
    send_cap(8'h55, 1'b1, 1'b0, 11, 0, seq, bc, dp);
    chk("post_rst_seq", seq, 16'h02A9);

    // Data_Valid held through three frames, dropped during the third stop
    @(posedge CLK); #1;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; P_DATA = DW'($urandom); Data_Valid = 1'b1;
    bc = 0; nd = 0;
    for (int i = 0; i < 60 && nd < 3; i++) begin
      @(negedge CLK);
      if (Busy) bc++;
      if (frame_done) nd++;
      P_DATA = DW'($urandom);
    end
    Data_Valid = 1'b0;
    chk("hold_frames", nd, 3);
    chk("hold_busy", bc, 30);
    bc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (Busy) bc++;
    end
    chk("hold_after", bc, 0);

    // Random traffic with occasional short asynchronous resets
    for (int i = 0; i < 400; i++) begin
      @(posedge CLK); #1;
      Data_Valid = ($urandom_range(0, 3) == 0);
      P_DATA     = DW'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #2 RST = 1'b1;
        #1 RST = 1'b0;
      end
    end
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
    repeat (15) @(negedge CLK);
    chk("final_idle", {TX_OUT, Busy}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
